reg_list_sequencer: RTL
=======================

// Module: reg_list_sequencer
// PURPOSE
//  Sequencer for LDM/STM-style block transfers. Walks a 16-bit register list in ascending order.
//  Drives the 4-bit select of the register-file 16:1 read mux, one register per accepted beat.
//  Generates the matching word address for each beat and handshakes each beat with the memory interface.
//  Sits between the control unit (Start/RegList/Base) and the regfile mux plus memory port.
// PARAMETERS
//  ADDR_W          32  width of base/transfer/writeback addresses
//  TIMEOUT_CYCLES  15  max cycles waiting for MemAck per beat (used only with SEQ_TIMEOUT_EN)
// PORTS
//  Clk       in   1       clock, rising edge
//  Clr       in   1       reset, asynchronous, active-low
//  Start     in   1       begin transfer; sampled only in IDLE
//  RegList   in   16      register list; bit n = Rn; sampled with Start
//  Up        in   1       1: increment addressing (IA); 0: decrement-before (DB); sampled with Start
//  Base      in   ADDR_W  base address; sampled with Start
//  MemAck    in   1       memory accepted current beat
//  S         out  4       mux select = index of register for current beat
//  SelValid  out  1       S/Addr valid; beat offered to memory
//  Addr      out  ADDR_W  word address of current beat
//  Busy      out  1       high from cycle after Start until Done cycle inclusive
//  Done      out  1       one-cycle pulse at normal completion
//  Count     out  5       popcount of latched RegList (0..16)
//  WbAddr    out  ADDR_W  writeback base: Base+4*Count (Up) or Base-4*Count (!Up); valid while Busy, held after
//  Err       out  1       one-cycle timeout abort pulse (tied 0 without SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE; S=0, SelValid=0, Addr=0, Busy=0, Done=0, Count=0, WbAddr=0, Err=0, mask=0.
//  Clr asserted mid-transfer aborts immediately; no Done/Err pulse; no further beats.
//  FSM IDLE -> XFER -> DONE -> IDLE; an empty list goes IDLE -> DONE.
//  IDLE: Start=1 latches RegList into mask, Up, Count=popcount, WbAddr.
//    Start address: Base if Up; Base-4*Count if !Up.
//    Next state: XFER if mask!=0, else DONE.
//  XFER: SelValid=1.
//    S = index of lowest set bit of mask; registers are always walked ascending, lowest register at lowest address.
//    MemAck=1 in a cycle clears that bit and adds 4 to Addr (mod 2^ADDR_W, wraps silently).
//    If the cleared bit was the last one, next state is DONE.
//    MemAck=0 holds S, Addr and mask stable.
//    Throughput: max one beat per cycle; same-cycle ack allowed.
//  DONE: Done=1, SelValid=0, Busy=1 for one cycle, then IDLE.
//  Start is ignored while Busy, including the DONE cycle; a new Start is accepted the cycle after DONE.
//  Latency: Start at cycle t gives the first SelValid at t+1. A list of N registers acked every cycle gives Done at t+N+1.
//  Empty list: no beats; Done at t+1; Count=0; WbAddr=Base.
//  MemAck outside XFER is ignored.
//  Address math is ADDR_W-bit modular; 4*Count is computed as {Count,2'b00} zero-extended.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//    A per-beat counter resets on each ack and on entry to XFER, and increments while SelValid & !MemAck.
//    When it reaches TIMEOUT_CYCLES: Err=1 for one cycle, SelValid=0, mask cleared, return to IDLE; no Done pulse.
//    Busy drops the cycle after Err.
//  SEQ_TIMEOUT_EN undefined: no counter logic; Err constant 0; XFER waits indefinitely for MemAck.
// TESTING
//  1. Reset: drive Clr=0 mid-XFER with RegList=16'h00F0 -> all outputs 0 next edge-free sample; no Done.
//  2. RegList=16'h8005, Base=32'h1000, Up=1, MemAck=1 always.
//     -> S=0,2,15 at Addr 1000,1004,1008; Count=3; WbAddr=32'h100C; Done at t+4.
//  3. RegList=16'h0003, Base=32'h2000, Up=0.
//     -> Addr 1FF8 (S=0), 1FFC (S=1); WbAddr=32'h1FF8.
//  4. Back-pressure: RegList=16'h0010, MemAck low 3 cycles then high.
//     -> S=4, Addr stable 4 cycles; single Done; Start pulsed during XFER ignored.
//  5. RegList=0 -> Done at t+1, SelValid never high, WbAddr=Base. Base=32'hFFFFFFFC, Up=1, list 16'h0003 -> Addr FFFFFFFC then 00000000.
//  6. SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=15, MemAck held 0 -> Err pulse after 15 SelValid cycles, no Done, IDLE; without macro Err stays 0.

Source files
------------

// File: rtl/reg_list_sequencer.sv
// LDM/STM block-transfer sequencer: walks RegList ascending, one register select + word address per beat.
// Latency: first beat the cycle after Start; Done N+1 cycles after Start when every beat is acked at once.
// Backpressure: MemAck low holds S/Addr/mask; optional per-beat timeout abort under SEQ_TIMEOUT_EN.
module reg_list_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic [15:0]       RegList,
    input  logic              Up,
    input  logic [ADDR_W-1:0] Base,
    input  logic              MemAck,
    output logic [3:0]        S,
    output logic              SelValid,
    output logic [ADDR_W-1:0] Addr,
    output logic              Busy,
    output logic              Done,
    output logic [4:0]        Count,
    output logic [ADDR_W-1:0] WbAddr,
    output logic              Err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        count_q, count_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

    logic [4:0]        start_cnt;
    logic [ADDR_W-1:0] start_off;
    logic [3:0]        low_idx;
    logic              timeout;

    always_comb begin
        start_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            start_cnt = start_cnt + {4'd0, RegList[i]};
        end
    end

    assign start_off = {{(ADDR_W-7){1'b0}}, start_cnt, 2'b00};

    // Priority from the top down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = i[3:0];
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = '0;
        if (state_q == ST_XFER && !MemAck) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Abort on the cycle that would complete TIMEOUT_CYCLES unacked offers.
    assign timeout = (state_q == ST_XFER) && !MemAck &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        count_d   = count_q;
        wb_addr_d = wb_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    mask_d    = RegList;
                    count_d   = start_cnt;
                    addr_d    = Up ? Base : Base - start_off;
                    wb_addr_d = Up ? Base + start_off : Base - start_off;
                    state_d   = (RegList != 16'd0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (timeout) begin
                    mask_d  = '0;
                    state_d = ST_ERR;
                end else if (MemAck) begin
                    mask_d = mask_q & (mask_q - 16'd1);
                    addr_d = addr_q + ADDR_W'(4);
                    if (mask_d == 16'd0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            wb_addr_q <= wb_addr_d;
        end
    end

    assign S        = low_idx;
    assign SelValid = (state_q == ST_XFER);
    assign Addr     = addr_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Done     = (state_q == ST_DONE);
    assign Count    = count_q;
    assign WbAddr   = wb_addr_q;
`ifdef SEQ_TIMEOUT_EN
    assign Err      = (state_q == ST_ERR);
`else
    assign Err      = 1'b0;
`endif

endmodule
